// File: rtl/fan_speed_ramp_ctrl.sv
// fan_speed_ramp_ctrl
//   Multi-level fan speed controller. Each level has a target duty. The
//   duty register ramps towards that target (soft start / soft stop), and a
//   PWM generator only picks up a new duty at a period boundary, so no
//   period is ever cut short or stretched.
//
// Ports
//   clk      : system clock
//   reset_n  : asynchronous, active-low reset
//   btn_up   : single-cycle pulse, next level (wraps LEVELS -> 0)
//   btn_dn   : single-cycle pulse, previous level (saturates at 0)
//   fan_en   : run enable; when low the level is forced to 0 and the duty ramps down
//   level    : current speed level, 0..LEVELS
//   led_bar  : thermometer code of level (bit i set iff level > i)
//   duty     : current ramped duty
//   ramping  : high while duty differs from the level's target
//   pwm      : fan PWM output
module fan_speed_ramp_ctrl #(
  parameter int SYS_FREQ = 125,     // MHz
  parameter int N        = 12,      // duty / PWM counter width
  parameter int LEVELS   = 7,       // non-zero speed levels, 1..255
  parameter int PWM_FREQ = 200,     // Hz
  parameter int RAMP_CYC = 125000,  // clocks per ramp tick, >= 1
  parameter int RAMP_INC = 16       // duty change per tick, 0 = instant step
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              btn_up,
  input  logic              btn_dn,
  input  logic              fan_en,
  output logic [7:0]        level,
  output logic [LEVELS-1:0] led_bar,
  output logic [N-1:0]      duty,
  output logic              ramping,
  output logic              pwm
);

  localparam logic [N-1:0] MAX       = {N{1'b1}};
  localparam int           STEP      = (2**N - 1) / LEVELS;
  localparam int           PRESC_RAW = (SYS_FREQ * 1_000_000) / (PWM_FREQ * (2**N));
  localparam int           PRESC     = (PRESC_RAW < 1) ? 1 : PRESC_RAW;
  localparam int           TW        = (RAMP_CYC > 1) ? $clog2(RAMP_CYC) : 1;
  localparam int           PW        = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [7:0]   LEVEL_TOP = 8'(LEVELS);
  localparam logic [N:0]   INC_W     = (N+1)'(RAMP_INC);

  logic [7:0]        level_nxt;
  logic [LEVELS-1:0] led_nxt;
  logic [N-1:0]      target;
  logic [N-1:0]      duty_nxt;
  logic [N:0]        duty_up;
  logic [N:0]        duty_dn;
  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic [PW-1:0]     presc_cnt;
  logic              presc_wrap;
  logic [N-1:0]      period_cnt;
  logic [N-1:0]      duty_latched;
  logic              pwm_nxt;

  // Level and its thermometer code. Simultaneous up+down cancels out.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    level_nxt = level;
    led_nxt   = '0;
    if (!fan_en) begin
      level_nxt = '0;
    end else if (btn_up && !btn_dn) begin
      level_nxt = (level == LEVEL_TOP) ? 8'd0 : level + 8'd1;
    end else if (btn_dn && !btn_up) begin
      level_nxt = (level == 8'd0) ? 8'd0 : level - 8'd1;
    end
    for (int i = 0; i < LEVELS; i++) begin
      led_nxt[i] = (level_nxt > 8'(i));
    end
  end

  // Target duty. The top level maps to true full scale, since STEP*LEVELS
  // usually falls a little short of MAX.
  always_comb begin
    target = '0;
    if (level == LEVEL_TOP) begin
      target = MAX;
    end else if (level != 8'd0) begin
      target = N'((N+8)'(level) * (N+8)'(STEP));
    end
  end

  assign ramping = (duty != target);
  assign tick    = (tick_cnt == TW'(RAMP_CYC - 1));

  // Ramp step, done one bit wider so a step can neither overflow past MAX
  // nor underflow past 0 before being clamped to the target.
  always_comb begin
    duty_up  = {1'b0, duty} + INC_W;
    duty_dn  = ({1'b0, duty} < INC_W) ? '0 : {1'b0, duty} - INC_W;
    duty_nxt = duty;
    if (RAMP_INC == 0) begin
      duty_nxt = target;
    end else if (tick) begin
      if (duty < target) begin
        duty_nxt = (duty_up > {1'b0, target}) ? target : N'(duty_up);
      end else if (duty > target) begin
        duty_nxt = (duty_dn < {1'b0, target}) ? target : N'(duty_dn);
      end
    end
  end

  // PWM compare. The extremes are forced so 0 and MAX are truly flat.
  assign presc_wrap = (presc_cnt == PW'(PRESC - 1));

  always_comb begin
    if (duty_latched == '0) begin
      pwm_nxt = 1'b0;
    end else if (duty_latched == MAX) begin
      pwm_nxt = 1'b1;
    end else begin
      pwm_nxt = (period_cnt < duty_latched);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level        <= '0;
      led_bar      <= '0;
      duty         <= '0;
      tick_cnt     <= '0;
      presc_cnt    <= '0;
      period_cnt   <= '0;
      duty_latched <= '0;
      pwm          <= 1'b0;
    end else begin
      level    <= level_nxt;
      led_bar  <= led_nxt;
      duty     <= duty_nxt;
      // Free-running: level changes do not restart the tick phase.
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      pwm      <= pwm_nxt;
      if (presc_wrap) begin
        presc_cnt  <= '0;
        period_cnt <= period_cnt + N'(1);
        // New duty is adopted only as a fresh period begins.
        if (period_cnt == MAX) begin
          duty_latched <= duty;
        end
      end else begin
        presc_cnt <= presc_cnt + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fan_speed_ramp_ctrl.sv
// Testbench for fan_speed_ramp_ctrl. Three instances cover the ramping
// configuration (a), a tiny 4-bit PWM configuration (b) and an instant-step
// configuration (c). A behavioural model derives counter phases from the
// absolute cycle count since reset and is compared to every output on every
// falling edge.
module tb_fan_speed_ramp_ctrl;

  typedef struct {
    int l;      // LEVELS
    int maxv;   // 2^N-1
    int step;   // MAX/LEVELS
    int rc;     // RAMP_CYC
    int inc;    // RAMP_INC
    int presc;  // PWM prescaler
  } cfg_t;

  typedef struct {
    int k;      // clock edges since reset release
    int level;
    int duty;
    int dl;     // duty in effect for the current PWM period
    int pwm;
  } mdl_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic up [3];
  logic dn [3];
  logic en [3];

  logic [7:0]  level_a, level_b, level_c;
  logic [6:0]  led_a, led_c;
  logic [14:0] led_b;
  logic [11:0] duty_a, duty_c;
  logic [3:0]  duty_b;
  logic        ramping_a, ramping_b, ramping_c;
  logic        pwm_a, pwm_b, pwm_c;

  int n_cmp = 0;
  int n_bad = 0;
  cfg_t cfg [3];
  mdl_t m [3];

  always #5 clk = ~clk;

  fan_speed_ramp_ctrl #(.N(12), .LEVELS(7), .RAMP_CYC(4), .RAMP_INC(64)) u_a (
    .clk(clk), .reset_n(reset_n), .btn_up(up[0]), .btn_dn(dn[0]), .fan_en(en[0]),
    .level(level_a), .led_bar(led_a), .duty(duty_a), .ramping(ramping_a), .pwm(pwm_a));

  fan_speed_ramp_ctrl #(.SYS_FREQ(1), .N(4), .LEVELS(15), .PWM_FREQ(62500),
                        .RAMP_CYC(4), .RAMP_INC(0)) u_b (
    .clk(clk), .reset_n(reset_n), .btn_up(up[1]), .btn_dn(dn[1]), .fan_en(en[1]),
    .level(level_b), .led_bar(led_b), .duty(duty_b), .ramping(ramping_b), .pwm(pwm_b));

  fan_speed_ramp_ctrl #(.N(12), .LEVELS(7), .RAMP_CYC(4), .RAMP_INC(0)) u_c (
    .clk(clk), .reset_n(reset_n), .btn_up(up[2]), .btn_dn(dn[2]), .fan_en(en[2]),
    .level(level_c), .led_bar(led_c), .duty(duty_c), .ramping(ramping_c), .pwm(pwm_c));

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int tgt_of(input cfg_t c, input int lv);
    if (lv == 0) return 0;
    if (lv == c.l) return c.maxv;
    return lv * c.step;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One rising edge of the reference behaviour.
  function automatic mdl_t step_m(input mdl_t s, input cfg_t c,
                                  input logic u, input logic d, input logic e);
    mdl_t n;
    int   tgt;
    int   pos;
    n   = s;
    tgt = tgt_of(c, s.level);
    if (!e)            n.level = 0;
    else if (u && !d)  n.level = (s.level == c.l) ? 0 : s.level + 1;
    else if (d && !u)  n.level = (s.level == 0) ? 0 : s.level - 1;
    if (c.inc == 0) begin
      n.duty = tgt;
    end else if ((s.k % c.rc) == c.rc - 1) begin
      if (s.duty < tgt)      n.duty = imin(s.duty + c.inc, tgt);
      else if (s.duty > tgt) n.duty = imax(s.duty - c.inc, tgt);
    end
    pos = (s.k / c.presc) % (c.maxv + 1);
    if (s.dl == 0)           n.pwm = 0;
    else if (s.dl == c.maxv) n.pwm = 1;
    else                     n.pwm = (pos < s.dl) ? 1 : 0;
    if (((s.k + 1) % (c.presc * (c.maxv + 1))) == 0) n.dl = s.duty;
    n.k = s.k + 1;
    return n;
  endfunction

  task automatic check_inst(input string id, input int i, input int lv, input int led,
                            input int du, input int rp, input int pw);
    check({id, ".level"},   lv,  m[i].level);
    check({id, ".led_bar"}, led, (1 << m[i].level) - 1);
    check({id, ".duty"},    du,  m[i].duty);
    check({id, ".ramping"}, rp,  (m[i].duty != tgt_of(cfg[i], m[i].level)) ? 1 : 0);
    check({id, ".pwm"},     pw,  m[i].pwm);
  endtask

  task automatic check_all();
    check_inst("a", 0, int'(level_a), int'(led_a), int'(duty_a), int'(ramping_a), int'(pwm_a));
    check_inst("b", 1, int'(level_b), int'(led_b), int'(duty_b), int'(ramping_b), int'(pwm_b));
    check_inst("c", 2, int'(level_c), int'(led_c), int'(duty_c), int'(ramping_c), int'(pwm_c));
  endtask

  task automatic reset_models();
    for (int i = 0; i < 3; i++) m[i] = '{k: 0, level: 0, duty: 0, dl: 0, pwm: 0};
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    for (int i = 0; i < 3; i++) m[i] = step_m(m[i], cfg[i], up[i], dn[i], en[i]);
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) clk_cycle();
  endtask

  task automatic pulse_up(input int i);
    up[i] = 1'b1;
    clk_cycle();
    up[i] = 1'b0;
  endtask

  task automatic pwm_highs(input string tag, input int exp);
    int hi;
    hi = 0;
    for (int t = 0; t < 16; t++) begin
      clk_cycle();
      hi += int'(pwm_b);
    end
    check(tag, hi, exp);
  endtask

  initial begin
    int step_tbl [8];
    bit done;
    step_tbl = '{585, 1170, 1755, 2340, 2925, 3510, 4095, 0};
    cfg[0] = '{l: 7,  maxv: 4095, step: 585, rc: 4, inc: 64, presc: 152};
    cfg[1] = '{l: 15, maxv: 15,   step: 1,   rc: 4, inc: 0,  presc: 1};
    cfg[2] = '{l: 7,  maxv: 4095, step: 585, rc: 4, inc: 0,  presc: 152};
    for (int i = 0; i < 3; i++) begin
      up[i] = 1'b0; dn[i] = 1'b0; en[i] = 1'b1;
    end
    reset_models();

    // Reset held while the buttons toggle: everything stays at zero.
    repeat (6) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        up[i] = 1'($urandom_range(0, 1));
        dn[i] = 1'($urandom_range(0, 1));
      end
      check_all();
    end
    for (int i = 0; i < 3; i++) begin
      up[i] = 1'b0; dn[i] = 1'b0;
    end
    reset_n = 1'b1;
    run(20);

    // Instant stepping through all levels and the wrap back to off.
    for (int j = 0; j < 8; j++) begin
      pulse_up(2);
      clk_cycle();
      check("c.step_level", int'(level_c), (j + 1) % 8);
      check("c.step_duty", int'(duty_c), step_tbl[j]);
    end
    dn[2] = 1'b1; clk_cycle(); dn[2] = 1'b0;
    check("c.dn_at_zero", int'(level_c), 0);
    repeat (3) pulse_up(2);
    up[2] = 1'b1; dn[2] = 1'b1; clk_cycle(); up[2] = 1'b0; dn[2] = 1'b0;
    check("c.up_dn_same", int'(level_c), 3);
    dn[2] = 1'b1; clk_cycle(); dn[2] = 1'b0;
    check("c.dn_step", int'(level_c), 2);

    // Soft start from 0 to level 1, then soft stop via fan_en.
    pulse_up(0);
    done = 1'b0;
    for (int t = 0; t < 80 && !done; t++) begin
      clk_cycle();
      if (duty_a == 12'd585) done = 1'b1;
    end
    check("a.rise_end_duty", int'(duty_a), 585);
    check("a.rise_end_ramping", int'(ramping_a), 0);
    run(8);
    check("a.rise_hold", int'(duty_a), 585);
    en[0] = 1'b0;
    clk_cycle();
    check("a.stop_level", int'(level_a), 0);
    done = 1'b0;
    for (int t = 0; t < 80 && !done; t++) begin
      clk_cycle();
      if (duty_a == 12'd0) done = 1'b1;
    end
    check("a.fall_end_duty", int'(duty_a), 0);
    en[0] = 1'b1;

    // PWM high time per 16-cycle period, including both flat extremes.
    repeat (5) pulse_up(1);
    run(40);
    pwm_highs("b.highs_duty5", 5);
    pulse_up(1);
    pulse_up(1);
    run(3);
    pulse_up(1);
    run(40);
    pwm_highs("b.highs_duty8", 8);
    repeat (7) pulse_up(1);
    run(40);
    pwm_highs("b.highs_duty15", 16);
    pulse_up(1);
    run(40);
    pwm_highs("b.highs_duty0", 0);

    // Asynchronous reset in the middle of a ramp.
    repeat (3) pulse_up(0);
    repeat (5) pulse_up(1);
    done = 1'b0;
    for (int t = 0; t < 80 && !done; t++) begin
      clk_cycle();
      if (duty_a >= 12'd300) done = 1'b1;
    end
    check("a.pre_reset_ramping", int'(ramping_a), 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst.a_duty", int'(duty_a), 0);
    check("rst.a_level", int'(level_a), 0);
    check("rst.a_pwm", int'(pwm_a), 0);
    check("rst.b_duty", int'(duty_b), 0);
    check("rst.b_level", int'(level_b), 0);
    check("rst.b_pwm", int'(pwm_b), 0);
    reset_models();
    @(negedge clk);
    check_all();
    reset_n = 1'b1;
    run(10);

    // Randomised operation of all three instances.
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < 3; i++) begin
        en[i] = ($urandom_range(0, 99) != 0);
        up[i] = ($urandom_range(0, 14) == 0);
        dn[i] = ($urandom_range(0, 24) == 0);
      end
      clk_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
